regfile_scoreboard: RTL and testbench
=====================================

// Module: regfile_scoreboard
// PURPOSE
//  Parametrised multi-read-port register file with a per-register scoreboard for the pipelined core.
//  - Replaces the fixed 32x64, 2-read file.
//  - Adds same-cycle write-to-read bypass and busy tracking for in-flight destinations.
//  - Gates issue on a WAW check and flags RAW hazards per read port.
//  - Sits between decode (read/issue) and writeback (write/clear).
// PARAMETERS
//  DATA_WIDTH  64  bits per register
//  NUM_REGS    32  register count (>=2)
//  ADDR_WIDTH  $clog2(NUM_REGS)  register index width
//  NUM_RD      2   number of read ports (>=1)
//  ZERO_REG    31  index hard-wired to zero; never written, never busy
//  BYPASS      1   1: a read of the register being written returns wr_data the same cycle
// PORTS
//  clk          in   1                    clock; all state updates on rising edge
//  reset        in   1                    asynchronous, active-low reset
//  wr_en        in   1                    writeback strobe
//  wr_addr      in   ADDR_WIDTH           writeback destination
//  wr_data      in   DATA_WIDTH           writeback data
//  rd_addr      in   NUM_RD*ADDR_WIDTH    read indices; port k = [k*ADDR_WIDTH +: ADDR_WIDTH]
//  rd_data      out  NUM_RD*DATA_WIDTH    read data; port k = [k*DATA_WIDTH +: DATA_WIDTH]
//  rd_busy      out  NUM_RD               port k source has a pending write (RAW hazard)
//  issue_en     in   1                    request to mark issue_addr as pending
//  issue_addr   in   ADDR_WIDTH           destination of issuing instruction
//  issue_ready  out  1                    issue accepted this cycle if issue_en is high
//  busy_count   out  $clog2(NUM_REGS+1)   number of registers currently busy
// BEHAVIOUR
//  Clock and reset:
//  - Single clock domain, clk.
//  - reset is asynchronous and active-low; asserted => all registers = 0, all busy bits = 0, busy_count = 0.
//  - While reset is asserted: rd_data = 0, rd_busy = 0, issue_ready = 1. State changes are ignored.
//  - Deassertion is taken on the next clk edge.
//  Write:
//  - wr_en && wr_addr!=ZERO_REG => reg[wr_addr] <= wr_data and busy[wr_addr] <= 0.
//  - A write to a non-busy register is legal and only updates data.
//  - wr_addr >= NUM_REGS is ignored.
//  Read (combinational, 0-cycle latency):
//  - rd_addr==ZERO_REG or rd_addr>=NUM_REGS => rd_data = 0.
//  - Else if BYPASS && wr_en && wr_addr==rd_addr => rd_data = wr_data.
//  - Else rd_data = reg[rd_addr].
//  Hazard flag:
//  - rd_busy[k] = busy[rd_addr_k] && !(BYPASS && wr_en && wr_addr==rd_addr_k).
//  - ZERO_REG is never busy.
//  Issue handshake:
//  - issue_ready = !busy[issue_addr] || (wr_en && wr_addr==issue_addr).
//  - Accepted = issue_en && issue_ready. Accepted and issue_addr!=ZERO_REG => busy[issue_addr] <= 1.
//  - Not accepted => no state change. The requester holds issue_en/issue_addr until accepted.
//  - Accepted issue to ZERO_REG: no busy change, no count change.
//  Simultaneous events:
//  - Same-register issue and write in one cycle: data written, busy stays 1 (new owner), busy_count unchanged.
//  - Different registers: both take effect.
//  busy_count (registered):
//  - +1 per accepted set of a 0 busy bit; -1 per write clearing a 1 busy bit; net per cycle in {-1,0,+1}.
//  - busy_count always equals popcount(busy); no wrap, max NUM_REGS-1.
//  Reset mid-operation:
//  - Pending busy bits and data are discarded immediately.
//  - First post-reset cycle behaves as empty scoreboard.
// TESTING
//  1. Reset: hold reset=0 with wr_en=1, wr_addr=3, wr_data=5 -> rd_data=0 on all ports, busy_count=0, issue_ready=1.
//  2. Write/read/zero: write 0xDEAD_BEEF to r3, then write 0x1234 to r31. Next cycle rd_addr0=3, rd_addr1=31 -> 0xDEADBEEF, 0.
//  3. Bypass: r7=1. Same cycle wr_en, wr_addr=7, wr_data=9, rd_addr0=7 -> rd_data0=9 (BYPASS=1) or 1 (BYPASS=0). Next cycle rd_data0=9.
//  4. Scoreboard: issue r5 -> busy_count=1. rd_addr0=5 -> rd_busy0=1. Issue r5 again -> issue_ready=0, count stays 1. Write r5 -> rd_busy0=0, count=0.
//  5. Simultaneous: r5 busy; in one cycle issue r5 and write r5=0x42 -> issue accepted, busy[5]=1, count=1, reg5=0x42.
//  6. Async reset mid-op: issue r1, r2 (count=2), pull reset low between edges -> count=0 and reg data=0 before next edge.
//     Repeat 4 with NUM_RD=4, NUM_REGS=16, DATA_WIDTH=32.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Multi-read-port register file with a per-register busy scoreboard.
// Decode side reads and issues destinations; writeback side writes data and retires busy bits.

module regfile_scoreboard_rdport #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_REGS   = 32,
    parameter int ADDR_WIDTH = $clog2(NUM_REGS),
    parameter int ZERO_REG   = 31,
    parameter bit BYPASS     = 1'b1
) (
    input  logic                                en_i,
    input  logic [ADDR_WIDTH-1:0]               rd_addr_i,
    input  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_i,
    input  logic [NUM_REGS-1:0]                 busy_i,
    input  logic                                wr_en_i,
    input  logic [ADDR_WIDTH-1:0]               wr_addr_i,
    input  logic [DATA_WIDTH-1:0]               wr_data_i,
    output logic [DATA_WIDTH-1:0]               rd_data_o,
    output logic                                rd_busy_o
);
    logic in_range, is_zero, hit;

    always_comb begin
        in_range  = 32'(rd_addr_i) < NUM_REGS;
        is_zero   = 32'(rd_addr_i) == ZERO_REG;
        hit       = BYPASS && wr_en_i && (wr_addr_i == rd_addr_i);
        rd_data_o = '0;
        rd_busy_o = 1'b0;
        // en_i low (reset held) forces zero so a bypassed write cannot leak through
        if (en_i && in_range && !is_zero) begin
            rd_data_o = hit ? wr_data_i : regs_i[rd_addr_i];
            rd_busy_o = busy_i[rd_addr_i] && !hit;
        end
    end
endmodule

module regfile_scoreboard #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_REGS   = 32,
    parameter int ADDR_WIDTH = $clog2(NUM_REGS),
    parameter int NUM_RD     = 2,
    parameter int ZERO_REG   = 31,
    parameter bit BYPASS     = 1'b1,
    localparam int CNT_W     = $clog2(NUM_REGS + 1)
) (
    input  logic                         clk_i,
    input  logic                         reset_ni,
    input  logic                         wr_en_i,
    input  logic [ADDR_WIDTH-1:0]        wr_addr_i,
    input  logic [DATA_WIDTH-1:0]        wr_data_i,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr_i,
    output logic [NUM_RD*DATA_WIDTH-1:0] rd_data_o,
    output logic [NUM_RD-1:0]            rd_busy_o,
    input  logic                         issue_en_i,
    input  logic [ADDR_WIDTH-1:0]        issue_addr_i,
    output logic                         issue_ready_o,
    output logic [CNT_W-1:0]             busy_count_o
);
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q;
    logic [NUM_REGS-1:0]                 busy_q, busy_d, set_vec, clr_vec;
    logic [CNT_W-1:0]                    count_q, count_d;
    logic                                wr_ok, iss_ok, iss_busy, accept, inc, dec;

    always_comb begin
        wr_ok    = wr_en_i && (32'(wr_addr_i) < NUM_REGS) && (32'(wr_addr_i) != ZERO_REG);
        iss_ok   = (32'(issue_addr_i) < NUM_REGS) && (32'(issue_addr_i) != ZERO_REG);
        iss_busy = iss_ok && busy_q[issue_addr_i];
        // a retiring write to the same register frees it for the new owner this cycle
        issue_ready_o = !reset_ni || !iss_busy || (wr_en_i && (wr_addr_i == issue_addr_i));
        accept   = issue_en_i && issue_ready_o;

        set_vec = '0;
        clr_vec = '0;
        if (accept && iss_ok) set_vec[issue_addr_i] = 1'b1;
        if (wr_ok)            clr_vec[wr_addr_i]    = 1'b1;

        // set wins over clear so a same-register issue+write leaves the bit owned
        busy_d  = (busy_q & ~clr_vec) | set_vec;
        inc     = |(set_vec & ~busy_q);
        dec     = |(clr_vec & busy_q & ~set_vec);
        count_d = count_q + CNT_W'(inc) - CNT_W'(dec);
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            regs_q  <= '0;
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            if (wr_ok) regs_q[wr_addr_i] <= wr_data_i;
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

    assign busy_count_o = count_q;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        regfile_scoreboard_rdport #(
            .DATA_WIDTH (DATA_WIDTH),
            .NUM_REGS   (NUM_REGS),
            .ADDR_WIDTH (ADDR_WIDTH),
            .ZERO_REG   (ZERO_REG),
            .BYPASS     (BYPASS)
        ) u_rdport (
            .en_i      (reset_ni),
            .rd_addr_i (rd_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH]),
            .regs_i    (regs_q),
            .busy_i    (busy_q),
            .wr_en_i   (wr_en_i),
            .wr_addr_i (wr_addr_i),
            .wr_data_i (wr_data_i),
            .rd_data_o (rd_data_o[k*DATA_WIDTH +: DATA_WIDTH]),
            .rd_busy_o (rd_busy_o[k])
        );
    end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: default 32x64/2-port instance plus a
// 16x32/4-port instance without bypass.

module tb_regfile_scoreboard;
    localparam int DW = 64, NR = 32, AW = 5, NRD = 2, CW = 6;
    localparam int DW2 = 32, NR2 = 16, AW2 = 4, NRD2 = 4, CW2 = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic               wr_en, issue_en, issue_ready;
    logic [AW-1:0]      wr_addr, issue_addr;
    logic [DW-1:0]      wr_data;
    logic [NRD*AW-1:0]  rd_addr;
    logic [NRD*DW-1:0]  rd_data;
    logic [NRD-1:0]     rd_busy;
    logic [CW-1:0]      busy_count;

    logic               wr_en2, issue_en2, issue_ready2;
    logic [AW2-1:0]     wr_addr2, issue_addr2;
    logic [DW2-1:0]     wr_data2;
    logic [NRD2*AW2-1:0] rd_addr2;
    logic [NRD2*DW2-1:0] rd_data2;
    logic [NRD2-1:0]    rd_busy2;
    logic [CW2-1:0]     busy_count2;

    int n_chk = 0, n_fail = 0;

    regfile_scoreboard u_dut (
        .clk_i(clk), .reset_ni(rst_n),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_busy_o(rd_busy),
        .issue_en_i(issue_en), .issue_addr_i(issue_addr), .issue_ready_o(issue_ready),
        .busy_count_o(busy_count)
    );

    regfile_scoreboard #(
        .DATA_WIDTH(DW2), .NUM_REGS(NR2), .NUM_RD(NRD2), .ZERO_REG(15), .BYPASS(1'b0)
    ) u_dut2 (
        .clk_i(clk), .reset_ni(rst_n),
        .wr_en_i(wr_en2), .wr_addr_i(wr_addr2), .wr_data_i(wr_data2),
        .rd_addr_i(rd_addr2), .rd_data_o(rd_data2), .rd_busy_o(rd_busy2),
        .issue_en_i(issue_en2), .issue_addr_i(issue_addr2), .issue_ready_o(issue_ready2),
        .busy_count_o(busy_count2)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic idle();
        wr_en = 1'b0; issue_en = 1'b0;
    endtask

    initial begin
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'd5;
        rd_addr = {5'd3, 5'd3}; issue_en = 1'b0; issue_addr = 5'd0;
        wr_en2 = 1'b0; wr_addr2 = '0; wr_data2 = '0; rd_addr2 = '0;
        issue_en2 = 1'b0; issue_addr2 = '0;

        // reset held with a write pending
        #1 rst_n = 1'b0;
        #2;
        check("rst_rd0", rd_data[63:0], 64'd0);
        check("rst_rd1", rd_data[127:64], 64'd0);
        check("rst_cnt", busy_count, 0);
        check("rst_ready", issue_ready, 1'b1);
        tick();
        check("rst_edge_rd0", rd_data[63:0], 64'd0);
        check("rst_edge_cnt", busy_count, 0);
        #2 rst_n = 1'b1;
        idle();
        tick();

        // write / read / zero register
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'hDEAD_BEEF;
        tick();
        wr_addr = 5'd31; wr_data = 64'h1234;
        tick();
        idle(); rd_addr = {5'd31, 5'd3};
        mid();
        check("wr_r3", rd_data[63:0], 64'hDEAD_BEEF);
        check("wr_r31_zero", rd_data[127:64], 64'd0);
        check("wr_nobusy", rd_busy, 2'b00);

        // bypass
        tick();
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 64'd1;
        tick();
        wr_data = 64'd9; rd_addr = {5'd3, 5'd7};
        mid();
        check("byp_same", rd_data[63:0], 64'd9);
        check("byp_other", rd_data[127:64], 64'hDEAD_BEEF);
        tick();
        idle();
        mid();
        check("byp_next", rd_data[63:0], 64'd9);

        // scoreboard: issue, reissue blocked, retire
        tick();
        issue_en = 1'b1; issue_addr = 5'd5; rd_addr = {5'd0, 5'd5};
        mid();
        check("iss_ready", issue_ready, 1'b1);
        check("iss_prebusy", rd_busy[0], 1'b0);
        tick();
        mid();
        check("iss_cnt1", busy_count, 1);
        check("iss_raw", rd_busy[0], 1'b1);
        check("iss_blocked", issue_ready, 1'b0);
        tick();
        idle();
        mid();
        check("iss_cnt_hold", busy_count, 1);
        tick();
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'h55;
        mid();
        check("ret_byp_busy", rd_busy[0], 1'b0);
        check("ret_byp_data", rd_data[63:0], 64'h55);
        tick();
        idle();
        mid();
        check("ret_cnt0", busy_count, 0);
        check("ret_busy0", rd_busy[0], 1'b0);
        check("ret_data", rd_data[63:0], 64'h55);

        // simultaneous issue + write to a busy register
        tick();
        issue_en = 1'b1; issue_addr = 5'd5;
        tick();
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'h42;
        mid();
        check("sim_ready", issue_ready, 1'b1);
        check("sim_cnt_pre", busy_count, 1);
        tick();
        idle();
        mid();
        check("sim_cnt", busy_count, 1);
        check("sim_busy", rd_busy[0], 1'b1);
        check("sim_data", rd_data[63:0], 64'h42);

        // retire r5 while issuing to the zero register
        tick();
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'h43;
        issue_en = 1'b1; issue_addr = 5'd31; rd_addr = {5'd31, 5'd5};
        mid();
        check("zr_ready", issue_ready, 1'b1);
        tick();
        idle();
        mid();
        check("zr_cnt", busy_count, 0);
        check("zr_busy", rd_busy, 2'b00);
        check("zr_data", rd_data[63:0], 64'h43);

        // two busy registers, then asynchronous reset between edges
        tick();
        issue_en = 1'b1; issue_addr = 5'd1;
        tick();
        issue_addr = 5'd2; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'h77;
        tick();
        idle(); rd_addr = {5'd1, 5'd3};
        mid();
        check("mid_cnt2", busy_count, 2);
        check("mid_r3", rd_data[63:0], 64'h77);
        check("mid_busy", rd_busy, 2'b10);
        #2;
        rst_n = 1'b0;
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'h99;
        issue_en = 1'b1; issue_addr = 5'd1;
        #1;
        check("arst_cnt", busy_count, 0);
        check("arst_rd0", rd_data[63:0], 64'd0);
        check("arst_busy", rd_busy, 2'b00);
        check("arst_ready", issue_ready, 1'b1);
        tick();
        check("arst_hold_cnt", busy_count, 0);
        #1;
        rst_n = 1'b1;
        idle();
        mid();
        check("post_cnt", busy_count, 0);
        check("post_r3", rd_data[63:0], 64'd0);
        check("post_busy", rd_busy, 2'b00);
        issue_en = 1'b1;
        #1;
        check("post_ready", issue_ready, 1'b1);
        tick();
        idle();
        mid();
        check("post_iss_cnt", busy_count, 1);

        // 16x32, four ports, no bypass
        tick();
        issue_en2 = 1'b1; issue_addr2 = 4'd5;
        rd_addr2 = {4'd0, 4'd15, 4'd5, 4'd5};
        tick();
        mid();
        check("p4_blocked", issue_ready2, 1'b0);
        check("p4_cnt1", busy_count2, 1);
        check("p4_raw", rd_busy2, 4'b0011);
        tick();
        issue_en2 = 1'b0; wr_en2 = 1'b1; wr_addr2 = 4'd5; wr_data2 = 32'hAB;
        mid();
        check("p4_nobyp_busy", rd_busy2, 4'b0011);
        check("p4_nobyp_data", rd_data2[31:0], 32'd0);
        tick();
        wr_en2 = 1'b0;
        mid();
        check("p4_cnt0", busy_count2, 0);
        check("p4_busy0", rd_busy2, 4'b0000);
        check("p4_rd0", rd_data2[31:0], 32'hAB);
        check("p4_rd1", rd_data2[63:32], 32'hAB);
        check("p4_rd2_zero", rd_data2[95:64], 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
